shifter_pipe: RTL
=================

Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational left shifter.
- Supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Shift amount is taken from the low bits of dataB.
- Sits between the ALU operand mux and the result writeback, with a valid/ready handshake on both sides so the ALU can stall it.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, 8..64.
- PIPE, 2: number of register stages (1 or 2); 2 inserts a boundary after layer ceil(SHW/2).
- SHW, $clog2(WIDTH): derived shift-amount width; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline clear
- inValid  in  1  input operands valid
- inReady  out  1  block can accept an input this cycle
- dataA  in  WIDTH  operand to shift
- dataB  in  WIDTH  shift amount; only dataB[SHW-1:0] is used
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- outValid  out  1  dataOut/zero valid
- outReady  in  1  downstream accepts the result
- dataOut  out  WIDTH  shift result
- zero  out  1  dataOut == 0

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits cleared; outValid=0.
  - dataOut=0, zero=1 (zero reflects the cleared register).
  - inReady=1 after release.
- Transfer rules:
  - Input transfer when inValid & inReady; output transfer when outValid & outReady.
- Shift amount: shamt = dataB[SHW-1:0]; upper bits ignored, so dataB=WIDTH behaves as shamt 0.
- Shift semantics:
  - SLL: fill with 0 at the LSB.
  - SRL: fill with 0 at the MSB.
  - SRA: fill with dataA[WIDTH-1].
  - ROR: bits leaving the LSB re-enter at the MSB.
  - shamt=0 passes dataA unchanged in every mode.
- Datapath structure:
  - SHW layers; layer k shifts by 2^k when shamt[k]=1.
  - Layers are applied LSB layer first, matching the existing shifter.
  - op and the unused shamt bits travel with the data through the stage registers.
- Latency: PIPE cycles from input transfer to outValid, with outReady held high.
- Throughput: one result per cycle while outReady=1.
- Elastic stages:
  - Stage i loads when !valid_i | ready_(i+1); ready of the last stage is outReady.
  - inReady = !valid_1 | ready_2, a combinational chain back from outReady.
  - No bubble is inserted on stall release.
- Stall:
  - While outValid & !outReady, dataOut/zero/outValid hold stable.
  - Capacity is PIPE items; inReady falls once all stages are full.
- Zero flag: computed from the final-stage data and registered with it; never glitches while outValid is held.
- flush:
  - Clears every valid bit at the next edge.
  - Forces inReady=0 in the same cycle, so no input is accepted.
  - Data registers may keep stale values; outValid=0 next cycle.
- Simultaneous input and output transfer into a full pipe is legal and keeps occupancy constant.
- Reset asserted mid-operation discards all in-flight items immediately; no partial result is ever presented.
- X-safety: op values are fully decoded; no default-to-X.

Decomposition:
- Package shifter_pkg holds:
  - op encoding constants OP_SLL/OP_SRL/OP_SRA/OP_ROR;
  - a clog2 helper;
  - the stage-split function (layers per stage for a given SHW and PIPE).
- Sub-module shift_layer, parametrised by WIDTH and DIST (2^k):
  - one combinational layer with inputs en, op, fill-bit and data;
  - instantiated SHW times via generate.
- Top-level shifter_pipe holds only the stage registers and the handshake.

Test Plan (all scenarios WIDTH=32, PIPE=2 unless noted):
- SLL dataA=0x00000001, dataB=31, outReady=1 -> dataOut=0x80000000, zero=0, outValid exactly 2 cycles after accept.
- SRA dataA=0x80000000, dataB=4 -> 0xF8000000; SRL same operands -> 0x08000000; SRL dataA=0x80000000, dataB=31 -> 0x00000001.
- ROR dataA=0x000000F1, dataB=4 -> 0x1000000F; ROR dataA=0x12345678, dataB=0x20 (shamt 0) -> 0x12345678; SLL dataA=0x1, dataB=32 -> 0x00000001.
- Back-pressure: three back-to-back inputs 1,2,3 (SLL by 1) with outReady=0 -> inReady drops after two accepts; outValid holds dataOut=0x2 stable; releasing outReady yields 0x2, 0x4, 0x6 on consecutive cycles with no bubble.
- flush with two items in flight -> outValid=0 next cycle, inReady=0 during the flush cycle, no stale result delivered afterwards; zero=1 for SLL dataA=0x1, dataB=0 -> no, dataA=0x0 -> zero=1.
- Async reset asserted between clock edges with the pipe full -> outValid=0 and dataOut=0 immediately; PIPE=1 rerun of scenario 1 shows 1-cycle latency.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter:
// op encodings, width helper and stage split.
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Layers handled ahead of the first register.
    function automatic int stageSplit(input int shw, input int pipe);
        return (pipe >= 2) ? (shw + 1) / 2 : shw;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One layer of the log shifter: moves the
// operand by DIST bits when enabled.
module shift_layer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             fill,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Select the shifted or passed-through operand.
    always_comb begin
        dout = din;
        if (en) begin
            unique case (1'b1)
                (op == OP_SLL): dout = din << DIST;
                (op == OP_SRL): dout = din >> DIST;
                (op == OP_SRA): dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
                (op == OP_ROR): dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with elastic stages
// and valid/ready handshakes on both sides.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int SHW   = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [1:0]       op,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero
);

    localparam int SPLIT = stageSplit(SHW, PIPE);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] head [SPLIT+1];
    logic [WIDTH-1:0] finData;
    logic             finValid;
    logic             finLoad;

    assign shamt   = dataB[SHW-1:0];
    assign head[0] = dataA;
    assign finLoad = !outValid || outReady;

    for (genvar k = 0; k < SPLIT; k++) begin : gHead
        shift_layer #(
            .WIDTH(WIDTH),
            .DIST (1 << k)
        ) uLayer (
            .en  (shamt[k]),
            .op  (op),
            .fill(dataA[WIDTH-1]),
            .din (head[k]),
            .dout(head[k+1])
        );
    end

    if (PIPE == 2) begin : gTwo
        logic             midValid;
        logic [WIDTH-1:0] midData;
        logic [1:0]       midOp;
        logic [SHW-1:SPLIT] midShamt;
        logic             midFill;
        logic             midLoad;
        logic [WIDTH-1:0] tail [SPLIT:SHW];

        assign midLoad     = !midValid || finLoad;
        assign inReady     = midLoad && !flush;
        assign tail[SPLIT] = midData;
        assign finData     = tail[SHW];
        assign finValid    = midValid;

        // First stage: partial result plus the controls still needed.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                midValid <= 1'b0;
                midData  <= '0;
                midOp    <= OP_SLL;
                midShamt <= '0;
                midFill  <= 1'b0;
            end else begin
                if (flush) begin
                    midValid <= 1'b0;
                end else if (midLoad) begin
                    midValid <= inValid;
                end
                if (midLoad && inValid && !flush) begin
                    midData  <= head[SPLIT];
                    midOp    <= op;
                    midShamt <= shamt[SHW-1:SPLIT];
                    midFill  <= dataA[WIDTH-1];
                end
            end
        end

        for (genvar k = SPLIT; k < SHW; k++) begin : gTail
            shift_layer #(
                .WIDTH(WIDTH),
                .DIST (1 << k)
            ) uLayer (
                .en  (midShamt[k]),
                .op  (midOp),
                .fill(midFill),
                .din (tail[k]),
                .dout(tail[k+1])
            );
        end
    end else begin : gOne
        assign inReady  = finLoad && !flush;
        assign finData  = head[SHW];
        assign finValid = inValid;
    end

    // Final stage: result and its zero flag registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            dataOut  <= '0;
            zero     <= 1'b1;
        end else begin
            if (flush) begin
                outValid <= 1'b0;
            end else if (finLoad) begin
                outValid <= finValid;
            end
            if (finLoad && finValid && !flush) begin
                dataOut <= finData;
                zero    <= (finData == '0);
            end
        end
    end

endmodule
